// File: rtl/fir_transposed.sv
`default_nettype none
// ============================================================================
// Module      : fir_transposed
// Description : Parametrised N-tap transposed-form FIR filter with a
//               runtime-writable coefficient bank, valid qualification,
//               optional product rounding, per-stage saturation and sticky
//               overflow flags.
//
// Ports       : i_clk           - clock, all logic on the rising edge
//               i_rst           - synchronous active-high reset
//               i_valid         - input sample qualifier
//               iv_din          - signed input sample, Q1.(DATA_WIDTH-1)
//               i_coef_we       - coefficient write strobe
//               iv_coef_addr    - tap index to write
//               iv_coef         - signed coefficient, Q1.(COEF_WIDTH-1)
//               i_clr_flags     - clears the sticky overflow flags
//               o_valid         - one-cycle output qualifier
//               ov_dout         - signed filtered output y[n]
//               o_prod_overflow - sticky: a product was saturated
//               o_sum_overflow  - sticky: a partial sum was saturated
//
// Revision    : 1.0 - initial release
// ============================================================================
module fir_transposed #(
    parameter int DATA_WIDTH = 24,
    parameter int COEF_WIDTH = 24,
    parameter int NUM_TAPS   = 8,
    parameter int ROUND      = 0
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_valid,
    input  logic signed [DATA_WIDTH-1:0]   iv_din,
    input  logic                           i_coef_we,
    input  logic [$clog2(NUM_TAPS)-1:0]    iv_coef_addr,
    input  logic signed [COEF_WIDTH-1:0]   iv_coef,
    input  logic                           i_clr_flags,
    output logic                           o_valid,
    output logic signed [DATA_WIDTH-1:0]   ov_dout,
    output logic                           o_prod_overflow,
    output logic                           o_sum_overflow
);

    localparam int c_AW = $clog2(NUM_TAPS);
    localparam int c_PW = DATA_WIDTH + COEF_WIDTH;
    // Number of taps expressed at address width + 1 so the range check
    // compares like-sized operands.
    localparam logic [c_AW:0] c_NTAPS = (c_AW + 1)'(NUM_TAPS);
    // Half an LSB of the scaled result, added ahead of the shift when rounding.
    localparam logic signed [c_PW-1:0] c_RND =
        (ROUND != 0) ? (c_PW'(1) << (COEF_WIDTH - 2)) : '0;

    logic signed [COEF_WIDTH-1:0] r_coef [NUM_TAPS];
    logic signed [DATA_WIDTH-1:0] r_psum [1:NUM_TAPS-1];
    logic signed [DATA_WIDTH-1:0] r_dout;
    logic                         r_valid;
    logic                         r_prod_ov;
    logic                         r_sum_ov;

    logic signed [c_PW-1:0]       w_din_ext;
    logic signed [DATA_WIDTH-1:0] w_prod_sat [NUM_TAPS];
    logic [NUM_TAPS-1:0]          w_prod_ov;
    logic signed [DATA_WIDTH-1:0] w_sum_sat [NUM_TAPS-1];
    logic [NUM_TAPS-2:0]          w_sum_ov;

    assign w_din_ext = {{COEF_WIDTH{iv_din[DATA_WIDTH-1]}}, iv_din};

    // ------------------------------------------------------------------
    // Per-tap product: full-width multiply, optional rounding, rescale to
    // the sample format and clip to the DATA_WIDTH range.
    // ------------------------------------------------------------------
    for (genvar k = 0; k < NUM_TAPS; k++) begin : g_tap
        logic signed [c_PW-1:0] w_coef_ext;
        logic signed [c_PW-1:0] w_prod_full;
        logic signed [c_PW-1:0] w_prod_rnd;
        logic signed [c_PW-1:0] w_prod_sh;
        logic [c_PW-DATA_WIDTH:0] w_hi;

        assign w_coef_ext  = {{DATA_WIDTH{r_coef[k][COEF_WIDTH-1]}}, r_coef[k]};
        assign w_prod_full = w_din_ext * w_coef_ext;
        assign w_prod_rnd  = w_prod_full + c_RND;
        assign w_prod_sh   = w_prod_rnd >>> (COEF_WIDTH - 1);
        // The result fits only if every bit from the sign position of the
        // target width upward is a copy of the sign.
        assign w_hi         = w_prod_sh[c_PW-1:DATA_WIDTH-1];
        assign w_prod_ov[k] = ~((&w_hi) | ~(|w_hi));
        assign w_prod_sat[k] = w_prod_ov[k]
            ? {w_prod_sh[c_PW-1], {(DATA_WIDTH-1){~w_prod_sh[c_PW-1]}}}
            : w_prod_sh[DATA_WIDTH-1:0];
    end

    // ------------------------------------------------------------------
    // Adder chain: stage k adds its product to the partial sum held by
    // stage k+1; stage 0 produces the filter output.
    // ------------------------------------------------------------------
    for (genvar k = 0; k < NUM_TAPS - 1; k++) begin : g_sum
        logic signed [DATA_WIDTH:0] w_sum_full;

        assign w_sum_full = {w_prod_sat[k][DATA_WIDTH-1], w_prod_sat[k]}
                          + {r_psum[k+1][DATA_WIDTH-1], r_psum[k+1]};
        assign w_sum_ov[k]  = w_sum_full[DATA_WIDTH] ^ w_sum_full[DATA_WIDTH-1];
        assign w_sum_sat[k] = w_sum_ov[k]
            ? {w_sum_full[DATA_WIDTH], {(DATA_WIDTH-1){~w_sum_full[DATA_WIDTH]}}}
            : w_sum_full[DATA_WIDTH-1:0];
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid   <= 1'b0;
            r_dout    <= '0;
            r_prod_ov <= 1'b0;
            r_sum_ov  <= 1'b0;
            for (int k = 0; k < NUM_TAPS; k++) begin
                r_coef[k] <= '0;
            end
            for (int k = 1; k < NUM_TAPS; k++) begin
                r_psum[k] <= '0;
            end
        end else begin
            // The multiply reads the registered bank, so a write coinciding
            // with a sample only affects the following samples.
            if (i_coef_we && ({1'b0, iv_coef_addr} < c_NTAPS)) begin
                r_coef[iv_coef_addr] <= iv_coef;
            end

            r_valid <= i_valid;

            if (i_valid) begin
                r_psum[NUM_TAPS-1] <= w_prod_sat[NUM_TAPS-1];
                for (int k = 1; k <= NUM_TAPS - 2; k++) begin
                    r_psum[k] <= w_sum_sat[k];
                end
                r_dout <= w_sum_sat[0];
            end

            // Clear takes effect on any cycle; a new overflow on an accepted
            // sample wins over a simultaneous clear.
            r_prod_ov <= (r_prod_ov & ~i_clr_flags) | (i_valid & (|w_prod_ov));
            r_sum_ov  <= (r_sum_ov  & ~i_clr_flags) | (i_valid & (|w_sum_ov));
        end
    end

    assign o_valid         = r_valid;
    assign ov_dout         = r_dout;
    assign o_prod_overflow = r_prod_ov;
    assign o_sum_overflow  = r_sum_ov;

endmodule
`default_nettype wire

// File: tb/tb_fir_transposed.sv
`default_nettype none
// ============================================================================
// Module      : tb_fir_transposed
// Description : Scoreboard bench for fir_transposed. Directed samples push
//               hand-computed outputs into per-instance queues; monitors pop
//               and compare on every o_valid pulse.
//               dut1: 8/8-bit, 4 taps, truncation. dut2: 8/8-bit, 5 taps,
//               rounding (5 taps leaves unused addresses to write to).
//
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_transposed;

    typedef struct packed {
        logic [7:0] d;
        logic       p;
        logic       s;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // dut1 signals
    logic       rst1 = 1'b1, vld1 = 1'b0, cwe1 = 1'b0, clr1 = 1'b0;
    logic [7:0] din1 = '0, coef1 = '0;
    logic [1:0] addr1 = '0;
    logic       ov1, pov1, sov1;
    logic [7:0] dout1;

    // dut2 signals
    logic       rst2 = 1'b1, vld2 = 1'b0, cwe2 = 1'b0, clr2 = 1'b0;
    logic [7:0] din2 = '0, coef2 = '0;
    logic [2:0] addr2 = '0;
    logic       ov2, pov2, sov2;
    logic [7:0] dout2;

    exp_t q1[$];
    exp_t q2[$];
    int   n_vec = 0;
    int   n_err = 0;

    fir_transposed #(.DATA_WIDTH(8), .COEF_WIDTH(8), .NUM_TAPS(4), .ROUND(0)) dut1 (
        .i_clk(clk), .i_rst(rst1), .i_valid(vld1), .iv_din(din1),
        .i_coef_we(cwe1), .iv_coef_addr(addr1), .iv_coef(coef1),
        .i_clr_flags(clr1), .o_valid(ov1), .ov_dout(dout1),
        .o_prod_overflow(pov1), .o_sum_overflow(sov1)
    );

    fir_transposed #(.DATA_WIDTH(8), .COEF_WIDTH(8), .NUM_TAPS(5), .ROUND(1)) dut2 (
        .i_clk(clk), .i_rst(rst2), .i_valid(vld2), .iv_din(din2),
        .i_coef_we(cwe2), .iv_coef_addr(addr2), .iv_coef(coef2),
        .i_clr_flags(clr2), .o_valid(ov2), .ov_dout(dout2),
        .o_prod_overflow(pov2), .o_sum_overflow(sov2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (ov1 === 1'b1) begin
            if (q1.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL dut1 unexpected o_valid: dout %0h, no expected entry", dout1);
            end else begin
                exp_t e;
                e = q1.pop_front();
                chk("dut1 dout", 32'(dout1), 32'(e.d));
                chk("dut1 prod_ov", 32'(pov1), 32'(e.p));
                chk("dut1 sum_ov", 32'(sov1), 32'(e.s));
            end
        end
    end

    always @(negedge clk) begin
        if (ov2 === 1'b1) begin
            if (q2.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL dut2 unexpected o_valid: dout %0h, no expected entry", dout2);
            end else begin
                exp_t e;
                e = q2.pop_front();
                chk("dut2 dout", 32'(dout2), 32'(e.d));
                chk("dut2 prod_ov", 32'(pov2), 32'(e.p));
                chk("dut2 sum_ov", 32'(sov2), 32'(e.s));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wr1(input logic [1:0] a, input logic [7:0] c);
        cwe1 = 1'b1; addr1 = a; coef1 = c;
        tick();
        cwe1 = 1'b0;
    endtask

    task automatic wr1_all(input logic [7:0] c0, input logic [7:0] c1,
                           input logic [7:0] c2, input logic [7:0] c3);
        wr1(2'd0, c0); wr1(2'd1, c1); wr1(2'd2, c2); wr1(2'd3, c3);
    endtask

    task automatic send1(input logic [7:0] x, input logic [7:0] d, input logic p, input logic s);
        vld1 = 1'b1; din1 = x;
        q1.push_back({d, p, s});
        tick();
        vld1 = 1'b0; din1 = '0;
    endtask

    task automatic wr2(input logic [2:0] a, input logic [7:0] c);
        cwe2 = 1'b1; addr2 = a; coef2 = c;
        tick();
        cwe2 = 1'b0;
    endtask

    task automatic send2(input logic [7:0] x, input logic [7:0] d, input logic p, input logic s);
        vld2 = 1'b1; din2 = x;
        q2.push_back({d, p, s});
        tick();
        vld2 = 1'b0; din2 = '0;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        tick(); tick();
        rst1 = 1'b0; rst2 = 1'b0;
        tick();

        // Reset state
        chk("rst dout", 32'(dout1), 32'h0);
        chk("rst o_valid", 32'(ov1), 32'h0);
        chk("rst prod_ov", 32'(pov1), 32'h0);
        chk("rst sum_ov", 32'(sov1), 32'h0);
        chk("rst dut2 dout", 32'(dout2), 32'h0);

        // Impulse, all taps 0.5
        wr1_all(8'd64, 8'd64, 8'd64, 8'd64);
        send1(8'd64, 8'd32, 1'b0, 1'b0);
        send1(8'd0,  8'd32, 1'b0, 1'b0);
        send1(8'd0,  8'd32, 1'b0, 1'b0);
        send1(8'd0,  8'd32, 1'b0, 1'b0);
        send1(8'd0,  8'd0,  1'b0, 1'b0);

        // Tap ordering: 127*c >>> 7
        wr1_all(8'd16, 8'd32, 8'd48, 8'd64);
        send1(8'd127, 8'd15, 1'b0, 1'b0);
        send1(8'd0,   8'd31, 1'b0, 1'b0);
        send1(8'd0,   8'd47, 1'b0, 1'b0);
        send1(8'd0,   8'd63, 1'b0, 1'b0);
        send1(8'd0,   8'd0,  1'b0, 1'b0);

        // Sum saturation
        wr1_all(8'd127, 8'd127, 8'd127, 8'd127);
        send1(8'd127, 8'd126, 1'b0, 1'b0);
        send1(8'd127, 8'd127, 1'b0, 1'b1);
        send1(8'd127, 8'd127, 1'b0, 1'b1);
        send1(8'd127, 8'd127, 1'b0, 1'b1);
        clr1 = 1'b1;
        tick();
        clr1 = 1'b0;
        chk("clr prod_ov", 32'(pov1), 32'h0);
        chk("clr sum_ov", 32'(sov1), 32'h0);
        chk("clr o_valid", 32'(ov1), 32'h0);
        chk("clr dout hold", 32'(dout1), 32'd127);
        // Drain the saturated partial sums (s1=127, s2=127, s3=126)
        send1(8'd0, 8'd127, 1'b0, 1'b0);
        send1(8'd0, 8'd127, 1'b0, 1'b0);
        send1(8'd0, 8'd126, 1'b0, 1'b0);
        send1(8'd0, 8'd0,   1'b0, 1'b0);

        // Write/sample collision, gaps, truncation of small products
        wr1_all(8'd64, 8'd0, 8'd0, 8'd0);
        cwe1 = 1'b1; addr1 = 2'd0; coef1 = 8'd32;
        send1(8'd64, 8'd32, 1'b0, 1'b0);   // old coefficient 64 applies
        cwe1 = 1'b0;
        send1(8'd64, 8'd16, 1'b0, 1'b0);   // new coefficient 32 applies
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("gap o_valid", 32'(ov1), 32'h0);
            chk("gap dout hold", 32'(dout1), 32'd16);
        end
        wr1(2'd0, 8'd64);
        send1(8'd1,   8'd0,   1'b0, 1'b0); // 64>>>7 truncates to 0
        send1(8'hFF,  8'hFF,  1'b0, 1'b0); // -64>>>7 floors to -1

        // Product saturation: -1.0 * -1.0
        wr1(2'd0, 8'h80);
        send1(8'h80, 8'd127, 1'b1, 1'b0);
        send1(8'd0,  8'd0,   1'b1, 1'b0);

        // Reset mid-stream (product flag still set from above)
        wr1_all(8'd64, 8'd64, 8'd64, 8'd64);
        send1(8'd64, 8'd32, 1'b1, 1'b0);
        send1(8'd0,  8'd32, 1'b1, 1'b0);
        rst1 = 1'b1; vld1 = 1'b1; din1 = 8'd64;
        cwe1 = 1'b1; addr1 = 2'd1; coef1 = 8'd100;
        tick();
        rst1 = 1'b0; vld1 = 1'b0; din1 = '0; cwe1 = 1'b0;
        chk("midrst dout", 32'(dout1), 32'h0);
        chk("midrst o_valid", 32'(ov1), 32'h0);
        chk("midrst prod_ov", 32'(pov1), 32'h0);
        chk("midrst sum_ov", 32'(sov1), 32'h0);
        send1(8'd64, 8'd0, 1'b0, 1'b0);
        send1(8'd0,  8'd0, 1'b0, 1'b0);
        send1(8'd0,  8'd0, 1'b0, 1'b0);

        // dut2: rounding and out-of-range address
        wr2(3'd5, 8'd127);                 // ignored: only taps 0..4 exist
        wr2(3'd6, 8'd127);                 // ignored
        wr2(3'd0, 8'd64);
        send2(8'd1,  8'd1, 1'b0, 1'b0);    // (64+64)>>>7 = 1
        send2(8'd0,  8'd0, 1'b0, 1'b0);
        send2(8'd0,  8'd0, 1'b0, 1'b0);
        send2(8'd0,  8'd0, 1'b0, 1'b0);
        send2(8'd0,  8'd0, 1'b0, 1'b0);
        send2(8'hFF, 8'd0, 1'b0, 1'b0);    // (-64+64)>>>7 = 0
        send2(8'd3,  8'd2, 1'b0, 1'b0);    // (192+64)>>>7 = 2
        send2(8'd0,  8'd0, 1'b0, 1'b0);

        tick(); tick(); tick();
        chk("dut1 queue drained", 32'(q1.size()), 32'h0);
        chk("dut2 queue drained", 32'(q2.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fir_transposed.md
Name: fir_transposed

Overview:
- Parametrised N-tap transposed-form FIR filter; successor to the single-tap MAC cell.
- Adds a runtime-writable coefficient bank, valid handshake, product rounding option, saturating arithmetic and sticky overflow flags.
- Sits between the sample source (ADC/decimator) and downstream DSP; one sample accepted per qualified cycle.

Parameters:
- DATA_WIDTH, 24, sample and output width (signed, Q1.(DATA_WIDTH-1)).
- COEF_WIDTH, 24, coefficient width (signed, Q1.(COEF_WIDTH-1)).
- NUM_TAPS, 8, number of taps (>=2).
- ROUND, 0, 0 = truncate product (arithmetic shift), 1 = round half up before shift.

Ports:
- i_clk  in  1  clock, all logic on rising edge.
- i_rst  in  1  synchronous active-high reset.
- i_valid  in  1  input sample qualifier.
- iv_din  in  DATA_WIDTH  signed input sample.
- i_coef_we  in  1  coefficient write strobe.
- iv_coef_addr  in  clog2(NUM_TAPS)  tap index k to write.
- iv_coef  in  COEF_WIDTH  signed coefficient value.
- i_clr_flags  in  1  clears sticky overflow flags.
- o_valid  out  1  output sample qualifier, 1-cycle pulse.
- ov_dout  out  DATA_WIDTH  signed filtered output y[n].
- o_prod_overflow  out  1  sticky: any product saturated.
- o_sum_overflow  out  1  sticky: any partial sum saturated.

Behaviour:
- Reset: coef[0..N-1], partial sums s[1..N-1], ov_dout, o_valid, both flags all cleared to 0.
- Reset overrides all other inputs in the same cycle, including mid-stream samples and coef writes.
- Product p_k = iv_din * coef[k], full width DATA_WIDTH+COEF_WIDTH.
- Product scaling: ROUND=0 gives p_k >>> (COEF_WIDTH-1). ROUND=1 adds 2^(COEF_WIDTH-2) before the shift.
- Product saturation: saturate the scaled product to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]. Set o_prod_overflow on clip. Only -1.0 * -1.0 can clip.
- Sum saturation: each add is computed in DATA_WIDTH+1 bits, then saturated to the DATA_WIDTH range. Set o_sum_overflow on clip.
- On a cycle with i_valid=1, all updates are simultaneous:
  - s[N-1] <= sat(p_{N-1}).
  - s[k] <= sat(p_k + s[k+1]) for 1 <= k <= N-2.
  - ov_dout <= sat(p_0 + s[1]).
  - o_valid <= 1.
- On a cycle with i_valid=0: s[] and ov_dout hold, o_valid <= 0.
- Latency: ov_dout/o_valid valid 1 cycle after the accepting edge. Throughput is 1 sample/cycle; no backpressure.
- Output: y[n] = sum over k of c[k]*x[n-k], with saturation applied per stage (not once at the end).
- Coefficient write: coef[iv_coef_addr] <= iv_coef when i_coef_we=1.
  - Writes to an address >= NUM_TAPS are ignored.
  - Write and i_valid in the same cycle: the sample uses the old coefficient; the new value applies from the next accepted sample.
  - Partial sums are not flushed on a coefficient write.
- Flags: sticky until i_clr_flags=1 or reset.
  - Clear and a new overflow in the same cycle: flag ends set (set wins).
- Flags update only on accepted samples.

Test Plan:
Common setup: DATA_WIDTH=8, COEF_WIDTH=8, NUM_TAPS=4, ROUND=0.
1. Impulse: coefs 64,64,64,64 (0.5); din 64 then 0,0,0,0 with i_valid=1 every cycle -> ov_dout 32,32,32,32,0; o_valid high each following cycle; no flags.
2. Tap ordering: coefs 16,32,48,64; impulse 127 -> outputs 15,31,47,63,0 (127*c>>>7).
3. Sum saturation: coefs all 127; din 127 held for 4 samples -> outputs 126,127,127,127; o_sum_overflow=1 from 2nd output, o_prod_overflow=0. Pulse i_clr_flags with i_valid=0 -> both flags 0.
4. Product saturation: coef[0]=-128, others 0; din -128 -> ov_dout 127, o_prod_overflow=1. ROUND=1 run: coef[0]=64, din 1 -> ov_dout 1 (vs 0 with ROUND=0).
5. Write collision/gaps: coef[0]=64; in the same cycle write coef[0]=32 and accept din 64 -> output 32. Next accepted din 64 -> output 16 (plus tap contributions). i_valid gaps hold ov_dout and drop o_valid. A write to addr 5 changes nothing.
6. Reset mid-stream: after 2 samples of test 1, assert i_rst for 1 cycle together with i_valid=1 -> next cycle ov_dout=0, o_valid=0, flags 0. Subsequent input 64 -> output 0 (coefficients cleared).
